sram_req_bridge: RTL and testbench
==================================

// Module: sram_req_bridge
// PURPOSE
//  Upstream client of spi_sram_fifo. Converts single-beat valid/ready memory requests (8/16/32-bit,
//  byte-addressed) into the FIFO push / write_cmd / read_cmd / data_out_read sequence, and returns
//  read data on a one-cycle response strobe. Sits between the CPU/bus fabric and the SPI SRAM engine.
// PARAMETERS
//  FIFO_DEPTH     32  byte capacity of downstream FIFO; caps one command's payload
//  COALESCE_TMO   16  idle cycles before pending coalesced writes are flushed (only with macro)
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   synchronous active-low reset
//  req_valid        in   1   request present
//  req_ready        out  1   request accepted when req_valid&&req_ready
//  req_we           in   1   1=write, 0=read
//  req_addr         in   24  byte address
//  req_wdata        in   32  write data, LSB-aligned
//  req_be           in   4   size: 4'b0001=8b, 4'b0011=16b, 4'b1111=32b
//  rsp_valid        out  1   one-cycle strobe: read data valid / write accepted
//  rsp_rdata        out  32  read data, zero-extended above size; 0 for writes
//  rsp_err          out  1   with rsp_valid: illegal req_be, request dropped
//  sram_data_in     out  32  -> data_in;  sram_data_in_valid out 1 -> data_in_valid
//  sram_data_be     out  4   -> data_be (push width and read word width)
//  sram_write_cmd   out  1   -> write_cmd;  sram_read_cmd out 1 -> read_cmd
//  sram_read_size   out  6   -> read_cmd_size (bytes: 1,2,4)
//  sram_address     out  24  -> address
//  sram_data_out    in   32  <- data_out;  sram_data_out_read out 1 -> data_out_read
//  sram_done        in   1   <- done (1 = engine idle)
// BEHAVIOUR
//  Reset: all outputs 0, state INIT. INIT holds req_ready=0 until sram_done==1, then IDLE.
//  req_ready=1 only in IDLE. size: be 0001->1, 0011->2, 1111->4; else rsp_valid+rsp_err next cycle.
//  Write: ACCEPT -> PUSH (data_in_valid=1 one cycle, data_be=req_be) -> WCMD (write_cmd=1 one cycle,
//   address=req_addr) -> GAP (one cycle, sram_done ignored: engine deasserts it late) -> WAIT
//   (until sram_done==1) -> IDLE. rsp_valid for writes pulses in PUSH (posted write).
//  Read: ACCEPT -> RCMD (read_cmd=1, read_size, data_be=req_be) -> GAP -> WAIT -> POP: capture
//   sram_data_out & size mask into rsp_rdata, data_out_read=1 one cycle, rsp_valid=1 same cycle -> IDLE.
//  Min latency: write 4 cycles to IDLE + engine time; read rsp 1 cycle after done seen.
//  Command outputs are single-cycle pulses; address/be/size held stable from cmd until WAIT exits.
//  Reset mid-operation: return to INIT; no rsp emitted; downstream is reset by same rst_n.
//  No backpressure on rsp; consumer must sample the strobe.
// CONFIGURATION
//  SRAM_BRIDGE_COALESCE_EN defined: writes of equal req_be at address == pend_addr+pend_bytes
//   are pushed into FIFO without write_cmd; pend_bytes accumulates. Flush (WCMD at pend_base)
//   when: next write non-contiguous or different be, any read (flush before RCMD), pend_bytes+size
//   > FIFO_DEPTH, or COALESCE_TMO idle cycles. Writes still ack in PUSH. Read-after-write coherent.
//  Undefined: every write issues its own write_cmd; no pend_* registers.
// STRUCTURE
//  Package sram_bridge_pkg: state enum (INIT,IDLE,PUSH,WCMD,RCMD,GAP,WAIT,POP,FLUSH), be->size
//   function, size->mask function, BE_8/BE_16/BE_32 constants.
//  Sub-module sram_wr_coalescer (pend_base, pend_bytes, timeout counter, flush request), only
//   instantiated under SRAM_BRIDGE_COALESCE_EN.
// TESTING (bench instantiates spi_sram_fifo, FIFO_DEPTH=32, 50 MHz)
//  reset, hold req_valid -> req_ready stays 0 until done rises after init.
//  write 32'h12345678 be 1111 @0x2000, read be 1111 @0x2000 -> rsp_rdata 32'h12345678, err 0.
//  read be 0011 @0x2001 -> 32'h00003456; read be 0001 @0x2003 -> 32'h00000012.
//  req_be 4'b0101 -> rsp_valid with rsp_err=1, no sram_*_cmd pulse.
//  COALESCE_EN: 32 byte writes @0x3000.. -> exactly one write_cmd, address 0x3000; readback each byte.
//  COALESCE_EN: write @0x4000 then read @0x4000 -> flush write_cmd precedes read_cmd, data matches.

Source files
------------

// File: rtl/sram_bridge_pkg.sv
// Shared types and helpers for the SRAM request bridge.
// Optional write coalescing is enabled by defining SRAM_BRIDGE_COALESCE_EN.
package sram_bridge_pkg;

   localparam logic [3:0] BE_8  = 4'b0001;
   localparam logic [3:0] BE_16 = 4'b0011;
   localparam logic [3:0] BE_32 = 4'b1111;

   typedef enum logic [3:0] {
      INIT, IDLE, PUSH, WCMD, RCMD, GAP, WAIT, POP, FLUSH
   } state_t;

   // Where the FSM resumes once a coalesced flush has completed.
   typedef enum logic [1:0] {
      AFT_IDLE, AFT_PUSH, AFT_RCMD
   } after_t;

   // Byte count for a legal byte-enable pattern, 0 for an illegal one.
   function automatic logic [5:0] be_to_size(input logic [3:0] be);
      case (be)
         BE_8:    be_to_size = 6'd1;
         BE_16:   be_to_size = 6'd2;
         BE_32:   be_to_size = 6'd4;
         default: be_to_size = 6'd0;
      endcase
   endfunction

   // Mask keeping only the low 'size' bytes of a read word.
   function automatic logic [31:0] size_mask(input logic [5:0] size);
      case (size)
         6'd1:    size_mask = 32'h0000_00FF;
         6'd2:    size_mask = 32'h0000_FFFF;
         6'd4:    size_mask = 32'hFFFF_FFFF;
         default: size_mask = 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/sram_req_bridge_coalescer.sv
// Pending-write tracker for the SRAM bridge: remembers the base address, byte
// count and width of writes already pushed into the FIFO without a write_cmd,
// judges whether a new write can extend the run, and raises a flush request
// after COALESCE_TMO idle cycles. Used only with SRAM_BRIDGE_COALESCE_EN.
module sram_wr_coalescer
   import sram_bridge_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 32,
   parameter int unsigned COALESCE_TMO = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] i_chk_addr,
   input  logic [3:0]  i_chk_be,
   input  logic        i_append,
   input  logic [23:0] i_addr,
   input  logic [3:0]  i_be,
   input  logic        i_clear,
   input  logic        i_idle,
   output logic        o_pend,
   output logic        o_merge_ok,
   output logic [23:0] o_pend_base,
   output logic        o_flush_tmo
);

   localparam logic [7:0]  LP_DEPTH = 8'(FIFO_DEPTH);
   localparam logic [15:0] LP_TMO   = 16'(COALESCE_TMO);

   logic        r_pend;
   logic [23:0] r_base;
   logic [7:0]  r_bytes;
   logic [3:0]  r_be;
   logic [15:0] r_cnt;
   logic [7:0]  w_chk_size;
   logic [7:0]  w_app_size;

   assign w_chk_size  = {2'b00, be_to_size(i_chk_be)};
   assign w_app_size  = {2'b00, be_to_size(i_be)};
   assign o_pend      = r_pend;
   assign o_pend_base = r_base;
   assign o_flush_tmo = r_pend && (r_cnt == LP_TMO);
   // An empty run always accepts; otherwise same width, contiguous and within FIFO capacity.
   assign o_merge_ok  = !r_pend ||
                        ((i_chk_be == r_be) &&
                         (i_chk_addr == (r_base + 24'(r_bytes))) &&
                         ((r_bytes + w_chk_size) <= LP_DEPTH));

   // Pending-run bookkeeping and idle timeout counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pend  <= 1'b0;
         r_base  <= '0;
         r_bytes <= '0;
         r_be    <= '0;
         r_cnt   <= '0;
      end else if (i_clear) begin
         r_pend  <= 1'b0;
         r_bytes <= '0;
         r_cnt   <= '0;
      end else if (i_append) begin
         r_cnt <= '0;
         if (!r_pend) begin
            r_pend  <= 1'b1;
            r_base  <= i_addr;
            r_bytes <= w_app_size;
            r_be    <= i_be;
         end else begin
            r_bytes <= r_bytes + w_app_size;
         end
      end else if (i_idle && r_pend && (r_cnt != LP_TMO)) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/sram_req_bridge.sv
// Bridge from single-beat valid/ready memory requests to the spi_sram_fifo
// push / write_cmd / read_cmd / data_out_read protocol. Define
// SRAM_BRIDGE_COALESCE_EN to merge contiguous same-width writes into one
// write_cmd; otherwise every write issues its own command.
module sram_req_bridge
   import sram_bridge_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 32,
   parameter int unsigned COALESCE_TMO = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [23:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] sram_data_in,
   output logic        sram_data_in_valid,
   output logic [3:0]  sram_data_be,
   output logic        sram_write_cmd,
   output logic        sram_read_cmd,
   output logic [5:0]  sram_read_size,
   output logic [23:0] sram_address,
   input  logic [31:0] sram_data_out,
   output logic        sram_data_out_read,
   input  logic        sram_done
);

   // A FIFO shallower than one word (or a zero timeout) cannot work; such a build never accepts.
   localparam logic LP_CFG_OK = (FIFO_DEPTH >= 4) && (COALESCE_TMO >= 1);

   state_t      r_state, w_next;
   logic        r_we;
   logic [23:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_err;
   logic [5:0]  w_size;
   logic        w_be_ok;
   logic        w_ready;
   logic        w_accept;

`ifdef SRAM_BRIDGE_COALESCE_EN
   after_t      r_after;
   logic        r_fl;
   logic        w_pend;
   logic        w_merge_ok;
   logic        w_tmo;
   logic [23:0] w_pend_base;

   sram_wr_coalescer #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .COALESCE_TMO (COALESCE_TMO)
   ) u_coalescer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_chk_addr  (req_addr),
      .i_chk_be    (req_be),
      .i_append    (r_state == PUSH),
      .i_addr      (r_addr),
      .i_be        (r_be),
      .i_clear     (r_state == FLUSH),
      .i_idle      ((r_state == IDLE) && !w_accept),
      .o_pend      (w_pend),
      .o_merge_ok  (w_merge_ok),
      .o_pend_base (w_pend_base),
      .o_flush_tmo (w_tmo)
   );

   assign w_ready      = (r_state == IDLE) && LP_CFG_OK && !w_tmo;
   assign sram_address = r_fl ? w_pend_base : r_addr;
`else
   assign w_ready      = (r_state == IDLE) && LP_CFG_OK;
   assign sram_address = r_addr;
`endif

   assign w_size             = be_to_size(r_be);
   assign w_be_ok            = (be_to_size(req_be) != 6'd0);
   assign w_accept           = req_valid && w_ready;
   assign req_ready          = w_ready;
   assign sram_data_in       = r_wdata;
   assign sram_data_be       = r_be;
   assign sram_read_size     = w_size;
   assign rsp_valid          = (r_state == PUSH) || (r_state == POP) || r_err;
   assign rsp_err            = r_err;
   assign rsp_rdata          = (r_state == POP) ? (sram_data_out & size_mask(w_size)) : '0;

   // Next-state selection and single-cycle command strobes.
   always_comb begin
      w_next             = r_state;
      sram_data_in_valid = 1'b0;
      sram_write_cmd     = 1'b0;
      sram_read_cmd      = 1'b0;
      sram_data_out_read = 1'b0;
      case (r_state)
         INIT: if (sram_done) w_next = IDLE;
         IDLE: begin
            if (w_accept && w_be_ok) begin
`ifdef SRAM_BRIDGE_COALESCE_EN
               if (req_we) w_next = w_merge_ok ? PUSH : FLUSH;
               else        w_next = w_pend ? FLUSH : RCMD;
            end else if (w_tmo) begin
               w_next = FLUSH;
`else
               w_next = req_we ? PUSH : RCMD;
`endif
            end
         end
         PUSH: begin
            sram_data_in_valid = 1'b1;
`ifdef SRAM_BRIDGE_COALESCE_EN
            w_next = IDLE;
`else
            w_next = WCMD;
`endif
         end
         WCMD, FLUSH: begin
            sram_write_cmd = 1'b1;
            w_next         = GAP;
         end
         RCMD: begin
            sram_read_cmd = 1'b1;
            w_next        = GAP;
         end
         // The engine lowers done a cycle late, so it is not looked at here.
         GAP: w_next = WAIT;
         WAIT: begin
            if (sram_done) begin
`ifdef SRAM_BRIDGE_COALESCE_EN
               if (r_fl) begin
                  case (r_after)
                     AFT_PUSH: w_next = PUSH;
                     AFT_RCMD: w_next = RCMD;
                     default:  w_next = IDLE;
                  endcase
               end else begin
                  w_next = r_we ? IDLE : POP;
               end
`else
               w_next = r_we ? IDLE : POP;
`endif
            end
         end
         POP: begin
            sram_data_out_read = 1'b1;
            w_next             = IDLE;
         end
         default: w_next = INIT;
      endcase
   end

   // State register, request capture and error strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= INIT;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= w_accept && !w_be_ok;
         if (w_accept && w_be_ok) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
         end
      end
   end

`ifdef SRAM_BRIDGE_COALESCE_EN
   // Flush bookkeeping: the held request resumes after the flush's WAIT.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_after <= AFT_IDLE;
         r_fl    <= 1'b0;
      end else if ((r_state == IDLE) && (w_next == FLUSH)) begin
         r_fl    <= 1'b1;
         r_after <= !w_accept ? AFT_IDLE : (req_we ? AFT_PUSH : AFT_RCMD);
      end else if ((r_state == WAIT) && sram_done) begin
         r_fl    <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_sram_req_bridge.sv
// Bench for sram_req_bridge with a behavioural SPI SRAM engine model; a
// scoreboard queue holds expected responses, checked by a separate monitor.
module tb_sram_req_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [23:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] sram_data_in;
   logic        sram_data_in_valid;
   logic [3:0]  sram_data_be;
   logic        sram_write_cmd, sram_read_cmd;
   logic [5:0]  sram_read_size;
   logic [23:0] sram_address;
   logic [31:0] sram_data_out;
   logic        sram_data_out_read;
   logic        sram_done;

   int tests = 0;
   int fails = 0;

   typedef struct { string name; logic err; logic [31:0] rdata; } exp_t;
   exp_t exp_q[$];

   typedef struct { logic rd; logic [23:0] addr; } cmd_t;
   cmd_t cmd_log[$];
   int   n_wcmd = 0;
   int   n_rcmd = 0;

   always #10 clk = ~clk;

   sram_req_bridge #(.FIFO_DEPTH(32), .COALESCE_TMO(16)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_we             (req_we),
      .req_addr           (req_addr),
      .req_wdata          (req_wdata),
      .req_be             (req_be),
      .rsp_valid          (rsp_valid),
      .rsp_rdata          (rsp_rdata),
      .rsp_err            (rsp_err),
      .sram_data_in       (sram_data_in),
      .sram_data_in_valid (sram_data_in_valid),
      .sram_data_be       (sram_data_be),
      .sram_write_cmd     (sram_write_cmd),
      .sram_read_cmd      (sram_read_cmd),
      .sram_read_size     (sram_read_size),
      .sram_address       (sram_address),
      .sram_data_out      (sram_data_out),
      .sram_data_out_read (sram_data_out_read),
      .sram_done          (sram_done)
   );

   // ---------------- engine model ----------------
   logic [7:0]  e_fifo[$];
   logic [7:0]  e_mem[int];
   int          e_init, e_phase, e_cnt;
   logic        e_is_rd;
   logic [23:0] e_addr;
   logic [5:0]  e_size;

   always @(posedge clk) begin
      if (!rst_n) begin
         e_fifo.delete();
         sram_done     <= 1'b0;
         sram_data_out <= '0;
         e_init        <= 0;
         e_phase       <= 0;
      end else begin
         if (e_init < 20) begin
            e_init <= e_init + 1;
            if (e_init == 19) sram_done <= 1'b1;
         end
         if (sram_data_in_valid)
            for (int i = 0; i < 4; i++)
               if (sram_data_be[i]) e_fifo.push_back(sram_data_in[8*i +: 8]);
         if (sram_data_out_read) sram_data_out <= '0;
         if (sram_write_cmd || sram_read_cmd) begin
            cmd_log.push_back('{rd: sram_read_cmd, addr: sram_address});
            if (sram_write_cmd) n_wcmd++;
            else n_rcmd++;
            e_phase <= 1;
            e_is_rd <= sram_read_cmd;
            e_addr  <= sram_address;
            e_size  <= sram_read_size;
         end else if (e_phase == 1) begin
            sram_done <= 1'b0;
            e_phase   <= 2;
            e_cnt     <= 4;
         end else if (e_phase == 2) begin
            if (e_cnt == 0) begin
               int a;
               logic [31:0] w;
               a = int'(e_addr);
               if (e_is_rd) begin
                  w = '0;
                  for (int i = 0; i < int'(e_size); i++)
                     if (e_mem.exists(a + i)) w[8*i +: 8] = e_mem[a + i];
                  sram_data_out <= w;
               end else begin
                  while (e_fifo.size() > 0) begin
                     e_mem[a] = e_fifo.pop_front();
                     a++;
                  end
               end
               sram_done <= 1'b1;
               e_phase   <= 0;
            end else begin
               e_cnt <= e_cnt - 1;
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", rsp_rdata, rsp_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
               fails++;
               $display("FAIL %s: got rdata=%h err=%b, required rdata=%h err=%b",
                        e.name, rsp_rdata, rsp_err, e.rdata, e.err);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, want);
      end
   endtask

   task automatic send(input string name, input logic we, input logic [23:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      n = 0;
      while (!req_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         tests++; fails++;
         $display("FAIL %s_accept: got req_ready=0 after %0d cycles, required 1", name, n);
         req_valid = 1'b0;
      end else begin
         exp_q.push_back('{name: name, err: exp_err, rdata: exp_rdata});
         @(posedge clk);
         #1 req_valid = 1'b0;
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !req_ready) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         tests++; fails++;
         $display("FAIL %s_drain: got %0d responses outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion by 1 ms, required completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int base, wc0, viol, n;
      logic [31:0] exp_wc;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {59'd0, req_ready, rsp_valid, sram_write_cmd, sram_read_cmd, sram_data_in_valid},
            64'd0);
      check("reset_addr_be", {36'd0, sram_address, sram_data_be}, 64'd0);
      rst_n = 1'b1;

      // Request held during engine init must not be accepted before done rises.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h0; req_be = 4'b0001;
      viol = 0; n = 0;
      while (!sram_done && n < 100) begin
         if (req_ready) viol++;
         @(negedge clk);
         n++;
      end
      check("init_hold", {32'(viol), 31'd0, sram_done}, {32'd0, 31'd0, 1'b1});
      send("rd_init", 1'b0, 24'h0, 32'h0, 4'b0001, 32'h0, 1'b0);
      drain("rd_init");

      send("wr_2000", 1'b1, 24'h2000, 32'h1234_5678, 4'b1111, 32'h0, 1'b0);
      send("rd32_2000", 1'b0, 24'h2000, 32'h0, 4'b1111, 32'h1234_5678, 1'b0);
      send("rd16_2001", 1'b0, 24'h2001, 32'h0, 4'b0011, 32'h0000_3456, 1'b0);
      send("rd8_2003", 1'b0, 24'h2003, 32'h0, 4'b0001, 32'h0000_0012, 1'b0);
      drain("basic");

      wc0 = n_wcmd + n_rcmd;
      send("err_be0101", 1'b1, 24'h2200, 32'hFFFF_FFFF, 4'b0101, 32'h0, 1'b1);
      drain("err");
      repeat (30) @(negedge clk);
      check("err_no_cmd", 64'(n_wcmd + n_rcmd), 64'(wc0));

      send("wr16_2100", 1'b1, 24'h2100, 32'hAAAA_BEEF, 4'b0011, 32'h0, 1'b0);
      send("rd32_2100", 1'b0, 24'h2100, 32'h0, 4'b1111, 32'h0000_BEEF, 1'b0);
      drain("wr16");

      // 32 contiguous byte writes, then read each byte back.
      wc0 = n_wcmd; base = cmd_log.size();
      for (int i = 0; i < 32; i++)
         send("wr8_3000", 1'b1, 24'h3000 + 24'(i), {24'hDEADBE, 8'(8'hA0 + i)}, 4'b0001, 32'h0, 1'b0);
      for (int i = 0; i < 32; i++)
         send("rd8_3000", 1'b0, 24'h3000 + 24'(i), 32'h0, 4'b0001, 32'(8'hA0 + i), 1'b0);
      drain("burst");
`ifdef SRAM_BRIDGE_COALESCE_EN
      exp_wc = 32'd1;
`else
      exp_wc = 32'd32;
`endif
      check("burst_wcmd_count", 64'(n_wcmd - wc0), 64'(exp_wc));
      n = -1;
      for (int i = base; i < cmd_log.size(); i++)
         if (n < 0 && !cmd_log[i].rd) n = i;
      if (n < 0) check("burst_first_wcmd_addr", 64'hFFFF_FFFF, 64'h3000);
      else       check("burst_first_wcmd_addr", 64'(cmd_log[n].addr), 64'h3000);

      // Write then read the same word: write_cmd must precede read_cmd.
      base = cmd_log.size();
      send("wr_4000", 1'b1, 24'h4000, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0);
      send("rd_4000", 1'b0, 24'h4000, 32'h0, 4'b1111, 32'hCAFE_F00D, 1'b0);
      drain("raw");
      if (cmd_log.size() < base + 2) begin
         check("raw_cmd_count", 64'(cmd_log.size() - base), 64'd2);
      end else begin
         check("raw_first_is_wcmd", {39'd0, cmd_log[base].rd, cmd_log[base].addr}, {39'd0, 1'b0, 24'h4000});
         check("raw_then_rcmd", {39'd0, cmd_log[base+1].rd, cmd_log[base+1].addr}, {39'd0, 1'b1, 24'h4000});
      end

      // A lone write must reach the engine without further traffic.
      wc0 = n_wcmd;
      send("wr8_5000", 1'b1, 24'h5000, 32'h0000_005A, 4'b0001, 32'h0, 1'b0);
      drain("lone");
      repeat (40) @(negedge clk);
      check("lone_write_flushed", 64'(n_wcmd - wc0), 64'd1);
      send("rd8_5000", 1'b0, 24'h5000, 32'h0, 4'b0001, 32'h0000_005A, 1'b0);
      drain("lone_rd");

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
